// File: rtl/mul4_seq_ctrl_pkg.sv
// Shared definitions for the sequential shift-and-add multiplier controller.
package mul4_seq_ctrl_pkg;

   localparam int WIDTH_DEF = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/mul4_seq_ctrl_if.sv
// Requester-side bundle: start/operands in, busy/done/product back.
interface mul4_seq_ctrl_if
   import mul4_seq_ctrl_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
);

   logic               start;
   logic [WIDTH-1:0]   a;
   logic [WIDTH-1:0]   b;
   logic               busy;
   logic               done;
   logic [2*WIDTH-1:0] product;

   modport master (
      output start, a, b,
      input  busy, done, product
   );

   modport slave (
      input  start, a, b,
      output busy, done, product
   );

endinterface

// File: rtl/mul4_seq_ctrl_add_rc.sv
// Ripple-carry adder built from full-adder cells; shared by every iteration.
module fa (
   input  logic x,
   input  logic y,
   input  logic ci,
   output logic s,
   output logic co
);

   // Single-bit full adder.
   always_comb begin
      s  = x ^ y ^ ci;
      co = (x & y) | (ci & (x ^ y));
   end

endmodule

module add_rc
   import mul4_seq_ctrl_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   input  logic             ci,
   output logic [WIDTH:0]   s
);

   logic [WIDTH:0] carry;

   assign carry[0] = ci;

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      fa u_fa (
         .x  (x[i]),
         .y  (y[i]),
         .ci (carry[i]),
         .s  (s[i]),
         .co (carry[i+1])
      );
   end

   assign s[WIDTH] = carry[WIDTH];

endmodule

// File: rtl/mul4_seq_ctrl.sv
// Sequential WIDTH x WIDTH shift-and-add multiplier controller.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_IDLE | waiting for start; product holds the last result
//   ST_CALC | one partial product added and shifted per clock, busy=1
//   ST_DONE | product just loaded, done=1 for this single cycle
module mul4_seq_ctrl
   import mul4_seq_ctrl_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic           clk,
   input  logic           rst,
   mul4_seq_ctrl_if.slave bus
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_t           state;
   // The accumulator's extra top bit is always zero after the right shift,
   // so only the low WIDTH bits are stored.
   logic [WIDTH-1:0] acc;
   logic [WIDTH-1:0] mq;
   logic [WIDTH-1:0] mcand;
   logic [CW-1:0]    count;

   logic [WIDTH-1:0] addend;
   logic [WIDTH:0]   sum;
   logic [WIDTH-1:0] acc_next;
   logic [WIDTH-1:0] mq_next;

   // Partial product selection and the combined {acc, mq} right shift.
   always_comb begin
      addend   = mq[0] ? mcand : '0;
      acc_next = sum[WIDTH:1];
      mq_next  = {sum[0], mq[WIDTH-1:1]};
   end

   add_rc #(.WIDTH(WIDTH)) u_add (
      .x  (acc),
      .y  (addend),
      .ci (1'b0),
      .s  (sum)
   );

   // Sequencer: accept, iterate WIDTH times, pulse done, return to idle.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_IDLE;
         bus.busy    <= 1'b0;
         bus.done    <= 1'b0;
         bus.product <= '0;
         acc         <= '0;
         mq          <= '0;
         mcand       <= '0;
         count       <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               bus.done <= 1'b0;
               if (bus.start) begin
                  mcand    <= bus.a;
                  mq       <= bus.b;
                  acc      <= '0;
                  count    <= '0;
                  bus.busy <= 1'b1;
                  state    <= ST_CALC;
               end
            end
            ST_CALC: begin
               acc   <= acc_next;
               mq    <= mq_next;
               count <= count + 1'b1;
               if (count == LAST) begin
                  bus.product <= {acc_next, mq_next};
                  bus.busy    <= 1'b0;
                  bus.done    <= 1'b1;
                  state       <= ST_DONE;
               end
            end
            ST_DONE: begin
               bus.done <= 1'b0;
               state    <= ST_IDLE;
            end
            default: begin
               bus.busy <= 1'b0;
               bus.done <= 1'b0;
               state    <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mul4_seq_ctrl.sv
// Self-checking bench for mul4_seq_ctrl against an arithmetic reference.
module tb_mul4_seq_ctrl;

   logic clk = 1'b0;
   logic rst;

   mul4_seq_ctrl_if #(.WIDTH(4)) bus ();

   mul4_seq_ctrl #(.WIDTH(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int n_cmp  = 0;
   int n_fail = 0;
   logic [7:0] last_product = 8'h00;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One full transaction checked against the fixed timeline:
   // busy in cycles 1..4, done with a*b in cycle 5, idle in cycle 6.
   task automatic do_mul(input logic [3:0] av, input logic [3:0] bv);
      logic [7:0] exp;
      exp = 8'(av) * 8'(bv);
      bus.start = 1'b1;
      bus.a     = av;
      bus.b     = bv;
      tick();
      bus.start = 1'b0;
      bus.a     = 4'($urandom);
      bus.b     = 4'($urandom);
      for (int k = 1; k <= 4; k++) begin
         n_cmp++;
         if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
            n_fail++;
            $display("FAIL calc_flags a=%h b=%h cyc=%0d busy=%b done=%b want busy=1 done=0",
                     av, bv, k, bus.busy, bus.done);
         end
         n_cmp++;
         if (bus.product !== last_product) begin
            n_fail++;
            $display("FAIL product_hold a=%h b=%h cyc=%0d got=%h want=%h",
                     av, bv, k, bus.product, last_product);
         end
         tick();
      end
      n_cmp++;
      if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin
         n_fail++;
         $display("FAIL done_flags a=%h b=%h busy=%b done=%b want busy=0 done=1",
                  av, bv, bus.busy, bus.done);
      end
      n_cmp++;
      if (bus.product !== exp) begin
         n_fail++;
         $display("FAIL product a=%h b=%h got=%h want=%h", av, bv, bus.product, exp);
      end
      last_product = exp;
      tick();
      n_cmp++;
      if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.product !== exp) begin
         n_fail++;
         $display("FAIL after_done a=%h b=%h busy=%b done=%b product=%h want 0 0 %h",
                  av, bv, bus.busy, bus.done, bus.product, exp);
      end
   endtask

   task automatic test_reset();
      rst       = 1'b1;
      bus.start = 1'b0;
      bus.a     = 4'h0;
      bus.b     = 4'h0;
      repeat (3) tick();
      n_cmp++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.product !== 8'h00) begin
         n_fail++;
         $display("FAIL reset_state busy=%b done=%b product=%h want 0 0 00",
                  bus.busy, bus.done, bus.product);
      end
      rst = 1'b0;
      tick();
      n_cmp++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.product !== 8'h00) begin
         n_fail++;
         $display("FAIL idle_after_reset busy=%b done=%b product=%h want 0 0 00",
                  bus.busy, bus.done, bus.product);
      end
      last_product = 8'h00;
   endtask

   task automatic test_directed();
      do_mul(4'h4, 4'h1);
      do_mul(4'hF, 4'hF);
      do_mul(4'hC, 4'h9);
      do_mul(4'h0, 4'hB);
   endtask

   // start pulses during CALC and DONE must be ignored.
   task automatic test_ignore_start();
      bus.start = 1'b1;
      bus.a     = 4'h3;
      bus.b     = 4'h7;
      tick();
      bus.start = 1'b0;
      tick();
      bus.start = 1'b1;
      bus.a     = 4'hF;
      bus.b     = 4'hF;
      tick();
      bus.start = 1'b0;
      n_cmp++;
      if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
         n_fail++;
         $display("FAIL restart_calc busy=%b done=%b want busy=1 done=0", bus.busy, bus.done);
      end
      tick();
      tick();
      n_cmp++;
      if (bus.done !== 1'b1 || bus.product !== 8'h15) begin
         n_fail++;
         $display("FAIL restart_product done=%b product=%h want done=1 product=15",
                  bus.done, bus.product);
      end
      bus.start = 1'b1;
      bus.a     = 4'h2;
      bus.b     = 4'h2;
      tick();
      bus.start = 1'b0;
      n_cmp++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.product !== 8'h15) begin
         n_fail++;
         $display("FAIL start_in_done busy=%b done=%b product=%h want 0 0 15",
                  bus.busy, bus.done, bus.product);
      end
      for (int k = 0; k < 4; k++) begin
         tick();
         n_cmp++;
         if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            n_fail++;
            $display("FAIL no_extra_op k=%0d busy=%b done=%b want 0 0", k, bus.busy, bus.done);
         end
      end
      last_product = 8'h15;
   endtask

   // start held high: one result every 6 cycles.
   task automatic test_back_to_back();
      logic exp_done, exp_busy;
      logic [7:0] exp_prod;
      bus.start = 1'b1;
      bus.a     = 4'h5;
      bus.b     = 4'h5;
      for (int k = 1; k <= 18; k++) begin
         tick();
         exp_done = ((k % 6) == 5);
         exp_busy = ((k % 6) >= 1) && ((k % 6) <= 4);
         exp_prod = (k >= 5) ? 8'h19 : last_product;
         n_cmp++;
         if (bus.done !== exp_done || bus.busy !== exp_busy || bus.product !== exp_prod) begin
            n_fail++;
            $display("FAIL back_to_back cyc=%0d busy=%b done=%b product=%h want %b %b %h",
                     k, bus.busy, bus.done, bus.product, exp_busy, exp_done, exp_prod);
         end
      end
      bus.start    = 1'b0;
      last_product = 8'h19;
   endtask

   task automatic test_reset_mid();
      bus.start = 1'b1;
      bus.a     = 4'h9;
      bus.b     = 4'h7;
      tick();
      bus.start = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      n_cmp++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.product !== 8'h00) begin
         n_fail++;
         $display("FAIL reset_mid busy=%b done=%b product=%h want 0 0 00",
                  bus.busy, bus.done, bus.product);
      end
      last_product = 8'h00;
      for (int k = 0; k < 8; k++) begin
         tick();
         n_cmp++;
         if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_no_done k=%0d busy=%b done=%b want 0 0", k, bus.busy, bus.done);
         end
      end
      do_mul(4'h6, 4'h5);
   endtask

   task automatic test_sweep();
      for (int i = 0; i < 16; i++) begin
         for (int j = 0; j < 16; j++) begin
            do_mul(4'(i), 4'(j));
         end
      end
   endtask

   task automatic test_random();
      for (int n = 0; n < 24; n++) begin
         do_mul(4'($urandom), 4'($urandom));
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_ignore_start();
      test_back_to_back();
      test_reset_mid();
      test_sweep();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
